// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream to instruction-memory loader with PC handoff
//
// Packs a little-endian byte stream into DATA_WIDTH words, writes each word
// into instruction memory, then hands the program to the core through a
// prog_ready / prog_ack handshake.
//
// Ports:
//   clk, arst                 clock, asynchronous active-high reset
//   start                     one-cycle request to begin a new load
//   byte_valid/byte_data/     incoming byte stream; byte_last marks the
//   byte_last/byte_ready      final byte of the program
//   imem_w_en/imem_wr_addr/   instruction-memory write port (byte address,
//   imem_data_in              word aligned); addr/data hold outside writes
//   prog_ready/prog_ack       handoff to the program counter
//   busy/done/error           load status
//   word_count                words written in the current load (saturating)
module program_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  imem_w_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_data_in,
    output logic                  prog_ready,
    input  logic                  prog_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int LANES          = DATA_WIDTH / BYTE_WIDTH;
    localparam int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int MAX_WORDS      = MEM_DEPTH / BYTES_PER_WORD;
    localparam int TO_W           = $clog2(ACK_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] MAX_WORDS_A = ADDR_WIDTH'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES  = ADDR_WIDTH'(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0]     LAST_LANE   = LANE_W'(LANES - 1);
    localparam logic [TO_W-1:0]       TO_LAST     = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RECV     = 3'd1,
        S_WRITE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_RUN      = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t                 state_q;
    logic [LANE_W-1:0]      lane_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   last_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   byte_ready_q;
    logic                   imem_w_en_q;
    logic [ADDR_WIDTH-1:0]  imem_wr_addr_q;
    logic [DATA_WIDTH-1:0]  imem_data_in_q;
    logic                   prog_ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [ADDR_WIDTH-1:0]  word_count_q;

    logic                   accept;
    logic                   restart;
    logic [DATA_WIDTH-1:0]  packed_d;

    // byte_ready_q is only ever set while in RECV, so it alone qualifies a transfer
    assign accept  = byte_valid & byte_ready_q;
    // start is honoured only where no load or handoff is pending
    assign restart = start & ((state_q == S_IDLE) | (state_q == S_RUN) | (state_q == S_ERROR));

    // Current partial word with the incoming byte dropped into its lane
    always_comb begin
        packed_d = shift_q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                packed_d[i*BYTE_WIDTH +: BYTE_WIDTH] = byte_data;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q        <= S_IDLE;
            lane_q         <= '0;
            shift_q        <= '0;
            last_q         <= 1'b0;
            to_cnt_q       <= '0;
            byte_ready_q   <= 1'b0;
            imem_w_en_q    <= 1'b0;
            imem_wr_addr_q <= '0;
            imem_data_in_q <= '0;
            prog_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            word_count_q   <= '0;
        end else if (restart) begin
            state_q      <= S_RECV;
            lane_q       <= '0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            prog_ready_q <= 1'b0;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                S_RECV: begin
                    if (accept) begin
                        if (word_count_q == MAX_WORDS_A) begin
                            // Memory already full: drop the byte and stop
                            state_q      <= S_ERROR;
                            error_q      <= 1'b1;
                            byte_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end else if ((lane_q == LAST_LANE) || byte_last) begin
                            // Upper lanes of a short final word stay zero
                            state_q        <= S_WRITE;
                            imem_w_en_q    <= 1'b1;
                            imem_wr_addr_q <= word_count_q * WORD_BYTES;
                            imem_data_in_q <= packed_d;
                            last_q         <= byte_last;
                            byte_ready_q   <= 1'b0;
                        end else begin
                            shift_q <= packed_d;
                            lane_q  <= lane_q + LANE_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    imem_w_en_q <= 1'b0;
                    lane_q      <= '0;
                    shift_q     <= '0;
                    if (word_count_q != MAX_WORDS_A) begin
                        word_count_q <= word_count_q + ADDR_WIDTH'(1);
                    end
                    if (last_q) begin
                        state_q      <= S_WAIT_ACK;
                        prog_ready_q <= 1'b1;
                        to_cnt_q     <= '0;
                    end else begin
                        state_q      <= S_RECV;
                        byte_ready_q <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (prog_ack) begin
                        state_q <= S_RUN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (to_cnt_q == TO_LAST) begin
                        // prog_ready has been up for ACK_TIMEOUT cycles
                        state_q      <= S_ERROR;
                        error_q      <= 1'b1;
                        prog_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_IDLE, S_RUN, S_ERROR: begin
                    // Left only through restart
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_w_en    = imem_w_en_q;
    assign imem_wr_addr = imem_wr_addr_q;
    assign imem_data_in = imem_data_in_q;
    assign prog_ready   = prog_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
`timescale 1ns/1ps
module tb_program_loader;

    localparam int MEM_DEPTH   = 16;
    localparam int ACK_TIMEOUT = 256;
    localparam int MAX_WORDS   = MEM_DEPTH / 4;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic        imem_w_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_data_in;
    logic        prog_ready;
    logic        prog_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;
    wr_t exp_q[$];

    program_loader #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(32),
        .MEM_DEPTH(MEM_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .arst(arst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready),
        .imem_w_en(imem_w_en), .imem_wr_addr(imem_wr_addr), .imem_data_in(imem_data_in),
        .prog_ready(prog_ready), .prog_ack(prog_ack),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write is matched against the scoreboard, and the cycle
    // after a write must show prog_ready exactly when it was the final word.
    bit   rdy_chk = 1'b0;
    logic rdy_exp = 1'b0;
    always @(negedge clk) begin
        if (arst) begin
            rdy_chk = 1'b0;
        end else begin
            if (rdy_chk) begin
                check("prog_ready after write", {31'b0, prog_ready}, {31'b0, rdy_exp});
                rdy_chk = 1'b0;
            end
            if (imem_w_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected write: got addr %h data %h expected none", imem_wr_addr, imem_data_in);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write addr", imem_wr_addr, e.addr);
                    check("write data", imem_data_in, e.data);
                    rdy_chk = 1'b1;
                    rdy_exp = e.last;
                end
            end
        end
    end

    // Reference: little-endian packing, word i at byte address 4*i
    task automatic push_expected(input byte_q_t prog, input int nwords, input bit final_last);
        for (int w = 0; w < nwords; w++) begin
            wr_t e;
            e.addr = 32'(w * 4);
            e.data = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < prog.size()) e.data = e.data | (32'(prog[w*4+k]) << (8 * k));
            end
            e.last = final_last && (w == nwords - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        @(negedge clk);
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("byte handshake", {31'b0, byte_ready}, 32'h1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic load(input byte_q_t prog, input int gap_pct, input bit mid_start, input int ack_delay);
        int n  = prog.size();
        int nw = (n + 3) / 4;
        int t  = 0;
        push_expected(prog, nw, 1'b1);
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                start = mid_start;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(prog[i], (i == n - 1));
        end
        while (!prog_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("prog_ready asserted", {31'b0, prog_ready}, 32'h1);
        check("word_count at handoff", word_count, 32'(nw));
        check("busy during handoff", {31'b0, busy}, 32'h1);
        check("done before ack", {31'b0, done}, 32'h0);
        if (ack_delay >= 0) begin
            repeat (ack_delay) @(posedge clk);
            @(posedge clk); #1;
            prog_ack = 1'b1;
            @(posedge clk); #1;
            prog_ack = 1'b0;
            @(negedge clk);
            check("done after ack", {31'b0, done}, 32'h1);
            check("prog_ready held in run", {31'b0, prog_ready}, 32'h1);
            check("busy in run", {31'b0, busy}, 32'h0);
            check("error in run", {31'b0, error}, 32'h0);
            check("word_count in run", word_count, 32'(nw));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " byte_ready"}, {31'b0, byte_ready}, 32'h0);
        check({tag, " imem_w_en"}, {31'b0, imem_w_en}, 32'h0);
        check({tag, " imem_wr_addr"}, imem_wr_addr, 32'h0);
        check({tag, " imem_data_in"}, imem_data_in, 32'h0);
        check({tag, " prog_ready"}, {31'b0, prog_ready}, 32'h0);
        check({tag, " busy"}, {31'b0, busy}, 32'h0);
        check({tag, " done"}, {31'b0, done}, 32'h0);
        check({tag, " error"}, {31'b0, error}, 32'h0);
        check({tag, " word_count"}, word_count, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t pa, pb, pc, pr;
        int cnt;

        pa = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // prog_ack in IDLE has no effect
        @(posedge clk); #1;
        prog_ack = 1'b1;
        @(posedge clk); #1;
        prog_ack = 1'b0;
        @(negedge clk);
        check("ack in idle done", {31'b0, done}, 32'h0);

        // Directed programs
        load(pa, 0, 1'b0, 3);
        // Bytes offered outside RECV are refused
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("byte_ready in run", {31'b0, byte_ready}, 32'h0);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;

        load(pb, 0, 1'b0, 1);
        load(pa, 100, 1'b1, 0);

        // Short final word: byte_last on lane 0
        pc = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hE7};
        load(pc, 0, 1'b0, 2);

        // Exactly full memory completes normally
        pc = {};
        for (int i = 0; i < MAX_WORDS * 4; i++) pc.push_back(8'($urandom));
        load(pc, 20, 1'b0, 0);

        // Randomised programs
        for (int r = 0; r < 8; r++) begin
            pr = {};
            for (int i = 0; i < int'($urandom_range(1, MAX_WORDS * 4)); i++) pr.push_back(8'($urandom));
            load(pr, int'($urandom_range(0, 60)), 1'($urandom), int'($urandom_range(0, 5)));
        end

        // Overflow: one byte beyond capacity
        pc = {};
        for (int i = 0; i < MAX_WORDS * 4 + 1; i++) pc.push_back(8'($urandom));
        push_expected(pc, MAX_WORDS, 1'b0);
        pulse_start();
        for (int i = 0; i < MAX_WORDS * 4 + 1; i++) send_byte(pc[i], (i == MAX_WORDS * 4));
        @(negedge clk);
        check("overflow error", {31'b0, error}, 32'h1);
        check("overflow byte_ready", {31'b0, byte_ready}, 32'h0);
        check("overflow prog_ready", {31'b0, prog_ready}, 32'h0);
        check("overflow word_count", word_count, 32'(MAX_WORDS));
        repeat (4) @(negedge clk);
        check("overflow prog_ready later", {31'b0, prog_ready}, 32'h0);
        pulse_start();
        @(negedge clk);
        check("restart clears error", {31'b0, error}, 32'h0);
        check("restart byte_ready", {31'b0, byte_ready}, 32'h1);
        check("restart word_count", word_count, 32'h0);

        // Ack timeout
        load(pb, 0, 1'b0, -1);
        cnt = 1;
        while (cnt < 400) begin
            @(negedge clk);
            if (!prog_ready) break;
            cnt++;
        end
        check("prog_ready hold cycles", 32'(cnt), 32'(ACK_TIMEOUT));
        check("timeout error", {31'b0, error}, 32'h1);
        check("timeout prog_ready", {31'b0, prog_ready}, 32'h0);

        // Async reset during the write of word 2
        push_expected(pa, 1, 1'b0);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(pa[i], 1'b0);
        check("second write in flight", {31'b0, imem_w_en}, 32'h1);
        #1;
        arst = 1'b1;
        #1;
        check("arst w_en", {31'b0, imem_w_en}, 32'h0);
        check("arst busy", {31'b0, busy}, 32'h0);
        check("arst prog_ready", {31'b0, prog_ready}, 32'h0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        check_all_zero("post arst");
        load(pa, 0, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Loader that fills the instruction memory before the core runs.
- Accepts a little-endian byte stream over a valid/ready interface and packs each 4 bytes into a 32-bit instruction.
- Writes each word into instruction memory through its write port (w_en / wr_addr / data_in), then raises prog_ready to the program counter and waits for prog_ack.
- Sits between the external programming link and the processor's instruction-memory write port and PC handshake.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- BYTE_WIDTH, 8, stream symbol width.
- ADDR_WIDTH, 32, instruction-memory address width (byte address).
- MEM_DEPTH, 1024, instruction-memory capacity in bytes; maximum words = MEM_DEPTH/4.
- ACK_TIMEOUT, 256, cycles to wait for prog_ack before flagging an error.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a new load.
- byte_valid  in  1  stream byte valid.
- byte_data  in  BYTE_WIDTH  stream byte.
- byte_last  in  1  marks the final byte of the program; qualified by byte_valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_w_en  out  1  instruction-memory write strobe.
- imem_wr_addr  out  ADDR_WIDTH  write byte address (word aligned).
- imem_data_in  out  DATA_WIDTH  write data.
- prog_ready  out  1  program loaded; the core may fetch.
- prog_ack  in  1  core acknowledgement of prog_ready.
- busy  out  1  a load or handoff is in progress.
- done  out  1  handoff acknowledged; the core is running.
- error  out  1  overflow or ack timeout.
- word_count  out  ADDR_WIDTH  number of words written in the current load.

Behaviour:
- Reset (async, arst=1): state IDLE. All outputs 0, including byte_ready, imem_w_en, imem_wr_addr, imem_data_in, prog_ready, busy, done, error, word_count. The byte lane counter and word index are cleared.
- States and transitions:
  - IDLE: start=1 goes to RECV. Entering RECV clears word_count, the lane counter, the shift register, error and done.
  - RECV:
    - byte_ready=1; busy=1.
    - A byte is accepted on byte_valid & byte_ready and placed in bits [8*lane+7 : 8*lane] (lane 0 first).
    - When the accepted byte completes lane 3, or carries byte_last, go to WRITE. Unfilled upper lanes are zero-padded.
    - If a byte is accepted when word_count == MEM_DEPTH/4, go to ERROR; the byte is discarded.
  - WRITE:
    - Exactly one cycle. imem_w_en=1, imem_wr_addr = word_count*4, imem_data_in = packed word; byte_ready=0.
    - Next cycle: word_count increments and the lane counter clears.
    - If the word held byte_last, go to WAIT_ACK; otherwise return to RECV.
  - WAIT_ACK:
    - prog_ready=1, busy=1. A timeout counter increments each cycle.
    - prog_ack=1 goes to RUN.
    - Counter reaching ACK_TIMEOUT without an ack goes to ERROR.
  - RUN:
    - prog_ready=1 (held), done=1, busy=0.
    - start=1 drops prog_ready the next cycle and restarts as from IDLE, going to RECV.
  - ERROR:
    - error=1, prog_ready=0, byte_ready=0.
    - start=1 clears error and goes to RECV.
- Timing and latency:
  - First write occurs 1 cycle after the 4th byte is accepted.
  - Peak throughput: 4 bytes per 5 cycles.
  - prog_ready asserts the cycle after the final WRITE.
- Boundary conditions:
  - start while in RECV, WRITE or WAIT_ACK is ignored.
  - byte_valid outside RECV is not accepted (byte_ready=0).
  - prog_ack outside WAIT_ACK is ignored.
  - byte_last on lane 0 produces a write of {24'h0, byte}.
  - A program of exactly MEM_DEPTH/4 words completes normally; only a byte beyond capacity errors.
  - arst mid-load aborts immediately: all outputs 0 asynchronously. Memory contents already written are not cleared.
- imem_wr_addr and imem_data_in are registered and hold their last value outside WRITE. Only imem_w_en qualifies them.
- word_count saturates at MEM_DEPTH/4.

Test Plan:
- Load 8 bytes 13,00,00,00,93,00,10,00 (last on 8th), prog_ack 3 cycles after prog_ready -> two writes: addr 0 data 0x00000013, addr 4 data 0x00100093; word_count=2, prog_ready=1, then done=1.
- Load 6 bytes AA,BB,CC,DD,11,22 with last on 6th -> writes 0xDDCCBBAA@0 and 0x00002211@4; prog_ready asserts the cycle after the second write.
- Stream with byte_valid toggling every other cycle plus a start pulse mid-load -> packing unaffected, start ignored, same words/addresses as the contiguous case.
- MEM_DEPTH=16, stream 17 bytes -> 4 writes (addr 0..12), 17th byte causes error=1, prog_ready never asserts; a later start clears error and byte_ready=1.
- Complete a load but hold prog_ack=0 -> after ACK_TIMEOUT=256 cycles, error=1, prog_ready=0.
- Assert arst during the WRITE cycle of word 2 -> imem_w_en, busy and prog_ready go 0 asynchronously. After release, state is IDLE and a new start reloads from addr 0.
